// File: rtl/alu_pkg.sv
// Shared opcode definitions for the registered 8-bit ALU.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_MUL  = 4'h2,
    ALU_DIV  = 4'h3,
    ALU_SHL  = 4'h4,
    ALU_SHR  = 4'h5,
    ALU_ROL  = 4'h6,
    ALU_ROR  = 4'h7,
    ALU_AND  = 4'h8,
    ALU_OR   = 4'h9,
    ALU_XOR  = 4'hA,
    ALU_NOR  = 4'hB,
    ALU_NAND = 4'hC,
    ALU_XNOR = 4'hD,
    ALU_GT   = 4'hE,
    ALU_EQ   = 4'hF
  } alu_op_e;

endpackage

// File: rtl/alu_8bit_comb.sv
// Combinational core: maps (a, b, op) to result and the unsigned add carry.
module alu_8bit_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = a_i - b_i;
  assign prod = a_i * b_i;
  // Guarded so a zero divisor yields all-ones instead of X.
  assign quot = (b_i == '0) ? '1 : (a_i / b_i);

  assign carry_o = sum[WIDTH];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = sum[WIDTH-1:0];
      ALU_SUB:  result_o = diff;
      ALU_MUL:  result_o = prod;
      ALU_DIV:  result_o = quot;
      ALU_SHL:  result_o = {a_i[WIDTH-2:0], 1'b0};
      ALU_SHR:  result_o = {1'b0, a_i[WIDTH-1:1]};
      ALU_ROL:  result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
      ALU_ROR:  result_o = {a_i[0], a_i[WIDTH-1:1]};
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_NAND: result_o = ~(a_i & b_i);
      ALU_XNOR: result_o = ~(a_i ^ b_i);
      ALU_GT:   result_o[0] = (a_i > b_i);
      ALU_EQ:   result_o[0] = (a_i == b_i);
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_8bit.sv
// Single-cycle execute stage: registers the combinational ALU result and carry.
module alu_8bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] ALU_Sel,
  output logic [WIDTH-1:0]    ALU_Out,
  output logic                CarryOut
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             carry_d;
  logic             carry_q;

  alu_8bit_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a_i      (A),
    .b_i      (B),
    .op_i     (alu_op_e'(ALU_Sel)),
    .result_o (out_d),
    .carry_o  (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign ALU_Out  = out_q;
  assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed + randomised bench for alu_8bit using an expected-result queue.
module tb_alu_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   sel;
  logic [W-1:0] alu_out;
  logic         cout;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  alu_8bit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .ALU_Sel  (sel),
    .ALU_Out  (alu_out),
    .CarryOut (cout)
  );

  always #5 clk = ~clk;

  function automatic int model(int x, int y, int op);
    case (op)
      0:  return (x + y) % 256;
      1:  return (x - y + 256) % 256;
      2:  return (x * y) % 256;
      3:  return (y == 0) ? 255 : x / y;
      4:  return (x * 2) % 256;
      5:  return x / 2;
      6:  return ((x * 2) % 256) + (x / 128);
      7:  return (x / 2) + ((x % 2) * 128);
      8:  return x & y;
      9:  return x | y;
      10: return x ^ y;
      11: return 255 - (x | y);
      12: return 255 - (x & y);
      13: return 255 - (x ^ y);
      14: return (x > y) ? 1 : 0;
      default: return (x == y) ? 1 : 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one op at negedge, queue its expectation, compare #1 after the capturing edge.
  task automatic issue(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [3:0] op, input logic [W-1:0] exp_r);
    exp_t e;
    exp_t got;
    @(negedge clk);
    a = xa; b = xb; sel = op;
    e.r = exp_r;
    e.c = ((int'(xa) + int'(xb)) > 255);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got.r = alu_out;
    got.c = cout;
    if (sbq.size() == 0) begin
      check({tag, "_sbq_empty"}, 9'h1, 9'h0);
    end else begin
      e = sbq.pop_front();
      check(tag, {got.r, got.c}, {e.r, e.c});
    end
  endtask

  logic [W-1:0] sweep_exp [16];

  initial begin
    sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                  8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

    rst_n = 1'b0; a = 8'hAA; b = 8'h55; sel = 4'h0;
    #2;
    check("reset_async_out", {alu_out, cout}, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_out", {1'b0, alu_out}, 9'h000);
    check("reset_hold_carry", {8'h00, cout}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      issue($sformatf("sweep_op%0h", i), 8'h0A, 8'h02, 4'(i), sweep_exp[i]);
    issue("opcode_wrap", 8'h0A, 8'h02, 4'h0, 8'h0C);

    issue("carry_add", 8'hF6, 8'h0A, 4'h0, 8'h00);
    issue("carry_and", 8'hF6, 8'h0A, 4'h8, 8'h02);

    issue("rol_edge", 8'h81, 8'h00, 4'h6, 8'h03);
    issue("ror_edge", 8'h81, 8'h00, 4'h7, 8'hC0);
    issue("shl_edge", 8'h81, 8'h00, 4'h4, 8'h02);
    issue("shr_edge", 8'h81, 8'h00, 4'h5, 8'h40);

    issue("div_by_zero", 8'h05, 8'h00, 4'h3, 8'hFF);
    issue("sub_wrap", 8'h02, 8'h05, 4'h1, 8'hFD);
    issue("eq_equal", 8'h33, 8'h33, 4'hF, 8'h01);
    issue("gt_equal", 8'h33, 8'h33, 4'hE, 8'h00);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [3:0]   rop;
      ra  = 8'($urandom_range(0, 255));
      rb  = (i % 6 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 15));
      issue($sformatf("rand%0d_op%0h", i, rop), ra, rb, rop, 8'(model(int'(ra), int'(rb), int'(rop))));
    end

    // Mid-run reset: outputs clear with no clock edge, pending result discarded.
    issue("pre_reset", 8'hF6, 8'h0A, 4'hB, 8'h01);
    @(negedge clk);
    a = 8'h7F; b = 8'hC0; sel = 4'h9;
    #2;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("midrun_reset", {alu_out, cout}, 9'h000);
    @(posedge clk);
    #1;
    check("midrun_reset_edge", {alu_out, cout}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    issue("post_reset", 8'h7F, 8'hC0, 4'h9, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
